wsp_shift_sequencer: RTL and testbench

WSP_SHIFT_SEQUENCER -- requirements
Module: wsp_shift_sequencer

---
 rtl/wsp_shift_sequencer_if.sv | 66 ++++++
 rtl/wsp_shift_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_wsp_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wsp_shift_sequencer_if.sv
// Wrapper serial port (WSP) bundle between a host, the shift sequencer and the core.
// master: the sequencer side (drives WSP controls and WSI, consumes host requests and WSO).
// slave : the host/core side (issues requests, returns WSO, observes status).
interface wsp_shift_sequencer_if #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
);
    // Host request
    logic               start;
    logic               sel_wir;
    logic               cap_req;
    logic [CNT_W-1:0]   len;
    logic [MAX_LEN-1:0] shift_data;

    // Serial return from the core
    logic               WSO;

    // WSP controls and serial data toward the core
    logic               SelectWIR;
    logic               CaptureWR;
    logic               ShiftWR;
    logic               UpdateWR;
    logic               WSI;

    // Status back to the host
    logic               ready;
    logic               done;
    logic               err;
    logic [MAX_LEN-1:0] rx_data;

    modport master (
        input  start,
        input  sel_wir,
        input  cap_req,
        input  len,
        input  shift_data,
        input  WSO,
        output SelectWIR,
        output CaptureWR,
        output ShiftWR,
        output UpdateWR,
        output WSI,
        output ready,
        output done,
        output err,
        output rx_data
    );

    modport slave (
        output start,
        output sel_wir,
        output cap_req,
        output len,
        output shift_data,
        output WSO,
        input  SelectWIR,
        input  CaptureWR,
        input  ShiftWR,
        input  UpdateWR,
        input  WSI,
        input  ready,
        input  done,
        input  err,
        input  rx_data
    );
endinterface

// File: rtl/wsp_shift_sequencer.sv
// WSP shift sequencer: runs one IDLE -> [CAPTURE] -> SHIFT x len -> UPDATE -> DONE
// operation per accepted start, driving registered WSP controls and serial data.
// Optional feature macro: WSP_SEQ_CAPTURE_EN enables the CAPTURE state and the
// sampling of WSO into rx_data; without it cap_req/WSO are ignored and rx_data is 0.
module wsp_shift_sequencer #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 WRCK,
    input  logic                 RESET,
    wsp_shift_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Sequencer state and latched request
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic               sel_q, sel_d;

    // Registered outputs
    logic               select_wir_q, select_wir_d;
    logic               shift_wr_q, shift_wr_d;
    logic               update_wr_q, update_wr_d;
    logic               wsi_q, wsi_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

`ifdef WSP_SEQ_CAPTURE_EN
    logic               capture_wr_q, capture_wr_d;
    logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
`endif

    logic               len_ok_c;
    logic               cap_c;

    // A request is legal only for 1..MAX_LEN shift cycles
    assign len_ok_c = (bus.len != '0) && (bus.len <= CNT_W'(MAX_LEN));

`ifdef WSP_SEQ_CAPTURE_EN
    assign cap_c = bus.cap_req;
`else
    assign cap_c = 1'b0;
    logic unused_inputs;
    assign unused_inputs = bus.WSO ^ bus.cap_req;
`endif

    // Next-state, datapath and output decode; outputs follow the next state so they are
    // valid in the very cycle the state is entered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
`ifdef WSP_SEQ_CAPTURE_EN
        rx_data_d = rx_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_ok_c) begin
                        len_d   = bus.len;
                        data_d  = bus.shift_data;
                        sel_d   = bus.sel_wir;
                        cnt_d   = '0;
                        mask_d  = MAX_LEN'(1);
`ifdef WSP_SEQ_CAPTURE_EN
                        rx_data_d = '0;
`endif
                        state_d = cap_c ? CAPTURE : SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                state_d = SHIFT;
            end
            SHIFT: begin
`ifdef WSP_SEQ_CAPTURE_EN
                // mask_q is one-hot at the bit being shifted this cycle
                rx_data_d = rx_data_q | (mask_q & {MAX_LEN{bus.WSO}});
`endif
                if (cnt_q == len_q - CNT_W'(1)) begin
                    state_d = UPDATE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    mask_d = mask_q << 1;
                end
            end
            UPDATE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        select_wir_d = sel_d && (state_d == CAPTURE || state_d == SHIFT || state_d == UPDATE);
        shift_wr_d   = (state_d == SHIFT);
        update_wr_d  = (state_d == UPDATE);
        wsi_d        = (state_d == SHIFT) && (|(data_d & mask_d));
        ready_d      = (state_d == IDLE);
        done_d       = (state_d == DONE);
`ifdef WSP_SEQ_CAPTURE_EN
        capture_wr_d = (state_d == CAPTURE);
`endif
    end

    // State and latched-request registers
    always_ff @(posedge WRCK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
        end
    end

    // Output registers; reset aborts any operation with no UpdateWR or done
    always_ff @(posedge WRCK) begin
        if (RESET) begin
            select_wir_q <= 1'b0;
            shift_wr_q   <= 1'b0;
            update_wr_q  <= 1'b0;
            wsi_q        <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            select_wir_q <= select_wir_d;
            shift_wr_q   <= shift_wr_d;
            update_wr_q  <= update_wr_d;
            wsi_q        <= wsi_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef WSP_SEQ_CAPTURE_EN
    // Capture strobe and received-data registers
    always_ff @(posedge WRCK) begin
        if (RESET) begin
            capture_wr_q <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            capture_wr_q <= capture_wr_d;
            rx_data_q    <= rx_data_d;
        end
    end

    assign bus.CaptureWR = capture_wr_q;
    assign bus.rx_data   = rx_data_q;
`else
    assign bus.CaptureWR = 1'b0;
    assign bus.rx_data   = '0;
`endif

    assign bus.SelectWIR = select_wir_q;
    assign bus.ShiftWR   = shift_wr_q;
    assign bus.UpdateWR  = update_wr_q;
    assign bus.WSI       = wsi_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_wsp_shift_sequencer.sv
// Bench for wsp_shift_sequencer: cycle-level model of the operation timeline plus
// directed operations with hand-computed expectations.
`timescale 1ns/1ps
module tb_wsp_shift_sequencer;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
`ifdef WSP_SEQ_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wsp_shift_sequencer_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    logic loop_en = 1'b0;
    logic wso_drv = 1'b0;
    assign bus.WSO = loop_en ? bus.WSI : wso_drv;

    wsp_shift_sequencer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .WRCK  (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: position within the current operation ----------------
    bit           model_valid = 1'b0;
    bit           m_busy = 1'b0;
    int           m_t    = 0;      // cycle index after the start edge (1 = first op cycle)
    int           m_cap  = 0;
    int           m_len  = 0;
    bit           m_sel  = 1'b0;
    bit           m_err  = 1'b0;
    logic [31:0]  m_data = '0;
    logic [31:0]  m_rx   = '0;
    logic         wso_seen = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_t = 0; m_rx = '0; m_err = 1'b0; model_valid = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_busy) begin
                if (CAP_EN && m_t > m_cap && m_t <= m_cap + m_len)
                    m_rx = m_rx | (32'(wso_seen) << (m_t - m_cap - 1));
                if (m_t == m_cap + m_len + 2) begin
                    m_busy = 1'b0; m_t = 0;
                end else begin
                    m_t++;
                end
            end else if (bus.start === 1'b1) begin
                if (int'(bus.len) >= 1 && int'(bus.len) <= MAX_LEN) begin
                    m_busy = 1'b1; m_t = 1;
                    m_cap  = CAP_EN ? int'(bus.cap_req) : 0;
                    m_len  = int'(bus.len);
                    m_sel  = bus.sel_wir;
                    m_data = bus.shift_data;
                    m_rx   = '0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        bit in_cap, in_sh, in_up, in_dn, e_wsi;
        logic [31:0] sh;
        logic [7:0]  exp_ctrl;
        wso_seen = bus.WSO;
        if (model_valid) begin
            in_cap = m_busy && m_t >= 1 && m_t <= m_cap;
            in_sh  = m_busy && m_t > m_cap && m_t <= m_cap + m_len;
            in_up  = m_busy && m_t == m_cap + m_len + 1;
            in_dn  = m_busy && m_t == m_cap + m_len + 2;
            e_wsi  = 1'b0;
            if (in_sh) begin
                sh    = m_data >> (m_t - m_cap - 1);
                e_wsi = sh[0];
            end
            exp_ctrl = {m_sel && m_busy && !in_dn, in_cap, in_sh, in_up, e_wsi, !m_busy, in_dn, m_err};
            chk("ctrl{sel,cap,shift,upd,wsi,rdy,done,err}",
                64'({bus.SelectWIR, bus.CaptureWR, bus.ShiftWR, bus.UpdateWR,
                     bus.WSI, bus.ready, bus.done, bus.err}), 64'(exp_ctrl));
            chk("rx_data", 64'(bus.rx_data), 64'(m_rx));
        end
    end

    // ---------------- directed stimulus ----------------
    int          r_cap_first, r_sh_first, r_sh_cnt, r_upd_first, r_upd_cnt;
    int          r_done_first, r_done_cnt, r_sel_cnt, r_err_first, r_err_cnt;
    int          r_rdy_low, r_any_ctrl;
    logic [31:0] r_wsi_seq;

    task automatic run_op(input bit sel, input bit cap, input int len,
                          input logic [31:0] data, input int hold, input int window);
        @(negedge clk);
        bus.sel_wir = sel; bus.cap_req = cap; bus.len = CNT_W'(len);
        bus.shift_data = data; bus.start = 1'b1;
        r_cap_first = -1; r_sh_first = -1; r_sh_cnt = 0; r_upd_first = -1; r_upd_cnt = 0;
        r_done_first = -1; r_done_cnt = 0; r_sel_cnt = 0; r_err_first = -1; r_err_cnt = 0;
        r_rdy_low = 0; r_any_ctrl = 0; r_wsi_seq = '0;
        @(posedge clk);
        if (hold == 0) begin
            #1;
            bus.start = 1'b0;
        end
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            if (hold > 0 && c == hold) bus.start = 1'b0;
            if (bus.CaptureWR && r_cap_first < 0) r_cap_first = c;
            if (bus.ShiftWR) begin
                if (r_sh_first < 0) r_sh_first = c;
                r_wsi_seq = r_wsi_seq | (32'(bus.WSI) << r_sh_cnt);
                r_sh_cnt++;
            end
            if (bus.UpdateWR) begin
                if (r_upd_first < 0) r_upd_first = c;
                r_upd_cnt++;
            end
            if (bus.done) begin
                if (r_done_first < 0) r_done_first = c;
                r_done_cnt++;
            end
            if (bus.err) begin
                if (r_err_first < 0) r_err_first = c;
                r_err_cnt++;
            end
            if (bus.SelectWIR) r_sel_cnt++;
            if (!bus.ready) r_rdy_low++;
            if (bus.SelectWIR || bus.CaptureWR || bus.ShiftWR || bus.UpdateWR || bus.WSI || bus.done)
                r_any_ctrl++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a valid start held high: start must be ignored under reset
        bus.start = 1'b1; bus.sel_wir = 1'b1; bus.cap_req = 1'b1;
        bus.len = CNT_W'(5); bus.shift_data = 32'hFFFF_FFFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ctrl", 64'({bus.SelectWIR, bus.CaptureWR, bus.ShiftWR, bus.UpdateWR,
                               bus.WSI, bus.ready, bus.done, bus.err}), 64'(8'b0000_0100));
        chk("reset rx_data", 64'(bus.rx_data), 64'h0);
        rst = 1'b0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle ready", 64'(bus.ready), 64'h1);

        // Instruction load, WSO tied high
        loop_en = 1'b0; wso_drv = 1'b1;
        run_op(1'b1, 1'b0, 12, 32'b0100_1001_0010, 0, 18);
        chk("wir sel cycles",  64'(r_sel_cnt), 64'd13);
        chk("wir wsi seq",     64'(r_wsi_seq), 64'(32'b0100_1001_0010));
        chk("wir shift cnt",   64'(r_sh_cnt), 64'd12);
        chk("wir update cyc",  64'(r_upd_first), 64'd13);
        chk("wir done cyc",    64'(r_done_first), 64'd14);
        chk("wir no capture",  64'(r_cap_first), 64'(-1));
        chk("wir rx_data",     64'(bus.rx_data), CAP_EN ? 64'h0FFF : 64'h0);

        // Data loopback with capture request
        loop_en = 1'b1;
        run_op(1'b0, 1'b1, 8, 32'hA5, 0, 14);
        chk("lb capture cyc",  64'(r_cap_first), CAP_EN ? 64'd1 : 64'(-1));
        chk("lb first shift",  64'(r_sh_first), CAP_EN ? 64'd2 : 64'd1);
        chk("lb shift cnt",    64'(r_sh_cnt), 64'd8);
        chk("lb done cyc",     64'(r_done_first), CAP_EN ? 64'd11 : 64'd10);
        chk("lb sel cnt",      64'(r_sel_cnt), 64'd0);
        chk("lb rx_data",      64'(bus.rx_data), CAP_EN ? 64'hA5 : 64'h0);

        // Illegal lengths: zero and MAX_LEN+1
        run_op(1'b1, 1'b1, 0, 32'hFFFF_FFFF, 0, 6);
        chk("len0 err cyc",    64'(r_err_first), 64'd1);
        chk("len0 err cnt",    64'(r_err_cnt), 64'd1);
        chk("len0 ready low",  64'(r_rdy_low), 64'd0);
        chk("len0 no ctrl",    64'(r_any_ctrl), 64'd0);
        chk("len0 rx held",    64'(bus.rx_data), CAP_EN ? 64'hA5 : 64'h0);
        run_op(1'b0, 1'b0, 33, 32'hFFFF_FFFF, 0, 6);
        chk("len33 err cnt",   64'(r_err_cnt), 64'd1);
        chk("len33 no ctrl",   64'(r_any_ctrl), 64'd0);

        // Full-length loopback
        run_op(1'b0, 1'b1, 32, 32'hDEAD_BEEF, 0, 40);
        chk("max shift cnt",   64'(r_sh_cnt), 64'd32);
        chk("max wsi seq",     64'(r_wsi_seq), 64'hDEAD_BEEF);
        chk("max done cyc",    64'(r_done_first), CAP_EN ? 64'd35 : 64'd34);
        chk("max rx_data",     64'(bus.rx_data), CAP_EN ? 64'hDEAD_BEEF : 64'h0);

        // Start held high through most of the shift phase
        run_op(1'b0, 1'b0, 6, 32'h2D, 5, 12);
        chk("hold update cnt", 64'(r_upd_cnt), 64'd1);
        chk("hold done cnt",   64'(r_done_cnt), 64'd1);
        chk("hold err cnt",    64'(r_err_cnt), 64'd0);
        chk("hold rx_data",    64'(bus.rx_data), CAP_EN ? 64'h2D : 64'h0);

        // Reset during the 5th shift cycle
        loop_en = 1'b0; wso_drv = 1'b1;
        @(negedge clk);
        bus.sel_wir = 1'b1; bus.cap_req = 1'b0; bus.len = CNT_W'(10);
        bus.shift_data = 32'h3FF; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 5) begin
                chk("pre-reset shift", 64'(bus.ShiftWR), 64'h1);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort ctrl", 64'({bus.SelectWIR, bus.CaptureWR, bus.ShiftWR, bus.UpdateWR,
                               bus.WSI, bus.ready, bus.done, bus.err}), 64'(8'b0000_0100));
        chk("abort rx_data", 64'(bus.rx_data), 64'h0);
        r_upd_cnt = 0; r_done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.UpdateWR) r_upd_cnt++;
            if (bus.done) r_done_cnt++;
        end
        chk("abort no update", 64'(r_upd_cnt), 64'd0);
        chk("abort no done",   64'(r_done_cnt), 64'd0);

        // Capture request with a short shift
        run_op(1'b0, 1'b1, 4, 32'h6, 0, 10);
        chk("cap4 capture cyc", 64'(r_cap_first), CAP_EN ? 64'd1 : 64'(-1));
        chk("cap4 done cyc",    64'(r_done_first), CAP_EN ? 64'd7 : 64'd6);
        chk("cap4 rx_data",     64'(bus.rx_data), CAP_EN ? 64'hF : 64'h0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
